// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - shared defaults, FSM state type and lane slicing helper for psum_drain
package psum_drain_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int NUM_INP_DEF = 64;
  localparam int ADDR_W_DEF  = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Low bit index of lane k inside a packed row of bw-bit lanes.
  function automatic int lane_lsb(input int k, input int bw);
    return k * bw;
  endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// rtl/psum_skid_fifo.sv - two-entry registered FIFO holding drained psum rows
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_data : write one entry (caller guarantees space)
//   i_pop          : remove head entry (ignored when empty)
//   o_data         : head entry, straight from storage registers
//   o_cnt          : number of entries held (0..2)
module psum_skid_fifo #(
  parameter int W = 129
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign o_data = r_mem[r_rptr];
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - reads psum SRAM rows after compute, optional ReLU, streams rows out
//
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_start, i_relu_en   : begin drain (IDLE only); ReLU enable latched with start
//   o_psum_cen/o_psum_addr/i_psum_dout : psum SRAM read port (data one cycle after cen=0)
//   o_out_data/o_out_valid/i_out_ready/o_out_last : row stream, last on row NUM_INP-1
//   o_busy, o_done       : drain in progress; one-cycle completion pulse
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int NUM_INP = NUM_INP_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_relu_en,
  output logic                   o_psum_cen,
  output logic [ADDR_W-1:0]      o_psum_addr,
  input  logic [COL*PSUM_BW-1:0] i_psum_dout,
  output logic [COL*PSUM_BW-1:0] o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_out_last,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int DW = COL * PSUM_BW;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_relu_en;

  logic              w_pop;
  logic              w_issue;
  logic              w_last_addr;
  logic [2:0]        w_occ;
  logic [1:0]        w_cnt;
  logic [DW:0]       w_head;
  logic [DW-1:0]     w_relu_row;

  assign w_pop       = o_out_valid & i_out_ready;
  // Rows already committed (buffered + in flight) after this cycle's pop;
  // keeping this below 2 is what makes FIFO overflow impossible.
  assign w_occ       = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == ST_READ) && (w_occ < 3'd2);
  assign w_last_addr = (r_addr == ADDR_W'(NUM_INP - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_READ;
      ST_READ:  if (w_issue && w_last_addr) w_state_nxt = ST_DRAIN;
      // w_occ==0 means nothing in flight and the FIFO empties this cycle,
      // so done lands exactly one cycle after the final transfer.
      ST_DRAIN: if (w_occ == 3'd0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_psum_cen  = ~w_issue;
  assign o_psum_addr = r_addr;
  assign o_busy      = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign o_done      = (r_state == ST_DONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_relu_en       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_addr;
      if (r_state == ST_IDLE && i_start) begin
        r_relu_en <= i_relu_en;
        r_addr    <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  for (genvar k = 0; k < COL; k++) begin : g_lane
    logic [PSUM_BW-1:0] w_lane;
    assign w_lane = i_psum_dout[lane_lsb(k, PSUM_BW) +: PSUM_BW];
    assign w_relu_row[lane_lsb(k, PSUM_BW) +: PSUM_BW] =
      (r_relu_en && w_lane[PSUM_BW-1]) ? '0 : w_lane;
  end

  psum_skid_fifo #(
    .W (DW + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, w_relu_row}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_cnt   (w_cnt)
  );

  assign o_out_valid = (w_cnt != 2'd0);
  assign o_out_data  = w_head[DW-1:0];
  assign o_out_last  = o_out_valid & w_head[DW];

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - directed self-checking bench for psum_drain (64-row and 1-row builds)
module tb_psum_drain;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DW  = COL * BW;
  localparam int AW  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, relu_en, out_ready;
  logic          cen, out_valid, out_last, busy, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout, out_data;

  logic          start1, out_ready1;
  logic          cen1, out_valid1, out_last1, busy1, done1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1, out_data1;

  int n_checks = 0;
  int n_fail   = 0;

  psum_drain #(.COL(COL), .PSUM_BW(BW), .NUM_INP(64), .ADDR_W(AW)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_relu_en(relu_en),
    .o_psum_cen(cen), .o_psum_addr(addr), .i_psum_dout(dout),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_last(out_last), .o_busy(busy), .o_done(done)
  );

  psum_drain #(.COL(COL), .PSUM_BW(BW), .NUM_INP(1), .ADDR_W(AW)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start1), .i_relu_en(1'b0),
    .o_psum_cen(cen1), .o_psum_addr(addr1), .i_psum_dout(dout1),
    .o_out_data(out_data1), .o_out_valid(out_valid1), .i_out_ready(out_ready1),
    .o_out_last(out_last1), .o_busy(busy1), .o_done(done1)
  );

  function automatic logic [DW-1:0] exp_row(input int r, input bit relu);
    logic [DW-1:0] v;
    int x;
    v = '0;
    for (int k = 0; k < COL; k++) begin
      x = r * 8 + k - 20;
      if (relu && x < 0) x = 0;
      v[k*BW +: BW] = x[BW-1:0];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!cen)  dout  <= exp_row(int'(addr), 1'b0);
    if (!cen1) dout1 <= exp_row(int'(addr1), 1'b0);
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk_bit({tag, "_cen"},   cen, 1'b1);
    chk_int({tag, "_addr"},  int'(addr), 0);
    chk_bit({tag, "_valid"}, out_valid, 1'b0);
    chk_bit({tag, "_last"},  out_last, 1'b0);
    chk_bit({tag, "_busy"},  busy, 1'b0);
    chk_bit({tag, "_done"},  done, 1'b0);
  endtask

  // Full drain with out_ready held high; k counts rising edges since start was driven.
  task automatic run_full(input string tag, input bit relu, input bit disturb);
    @(negedge clk);
    start = 1'b1; relu_en = relu; out_ready = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk_bit({tag, "_cen_t1"}, cen, 1'b0);
        chk_int({tag, "_addr_t1"}, int'(addr), 0);
        chk_bit({tag, "_busy_t1"}, busy, 1'b1);
      end
      if (k >= 3 && k <= 66) begin
        chk_bit($sformatf("%s_valid_r%0d", tag, k - 3), out_valid, 1'b1);
        chk_row($sformatf("%s_data_r%0d", tag, k - 3), out_data, exp_row(k - 3, relu));
        chk_bit($sformatf("%s_last_r%0d", tag, k - 3), out_last, (k == 66));
      end else begin
        chk_bit($sformatf("%s_novalid_k%0d", tag, k), out_valid, 1'b0);
      end
      chk_bit($sformatf("%s_done_k%0d", tag, k), done, (k == 67));
      if (disturb && k == 13) begin
        start = 1'b1; relu_en = ~relu;
      end
      if (disturb && k == 14) start = 1'b0;
    end
  endtask

  initial begin
    int  got, issued, pop_i;
    bit  prev_hold, seen_done;
    logic [DW-1:0] prev_data;

    reset = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    chk_bit("rst1_cen", cen1, 1'b1);
    chk_bit("rst1_valid", out_valid1, 1'b0);
    reset = 1'b0;

    // 1: plain drain
    run_full("t1", 1'b0, 1'b0);

    // 2: ReLU drain, plus explicit spot checks on rows 0 and 3
    @(negedge clk);
    start = 1'b1; relu_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) chk_row("t2_row0_zero", out_data, '0);
      if (k == 6) chk_int("t2_row3_lane0", int'(out_data[BW-1:0]), 4);
    end
    repeat (64) @(negedge clk);
    chk_bit("t2_idle", busy, 1'b0);
    run_full("t2", 1'b1, 1'b0);

    // 3: out_ready pattern 1,0,0,1 with scoreboard, stability and credit checks
    got = 0; issued = 0; prev_hold = 1'b0; seen_done = 1'b0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; relu_en = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (prev_hold) begin
        chk_bit($sformatf("t3_hold_valid_c%0d", cyc), out_valid, 1'b1);
        chk_row($sformatf("t3_hold_data_c%0d", cyc), out_data, prev_data);
      end
      pop_i = (out_valid && out_ready) ? 1 : 0;
      if (!cen) chk_bit($sformatf("t3_credit_c%0d", cyc), (issued - got - pop_i) < 2, 1'b1);
      if (pop_i == 1) begin
        chk_row($sformatf("t3_data_r%0d", got), out_data, exp_row(got, 1'b0));
        chk_bit($sformatf("t3_last_r%0d", got), out_last, (got == 63));
        got++;
      end
      if (!cen) issued++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk_int("t3_rows", got, 64);
    chk_bit("t3_done_seen", seen_done, 1'b1);
    out_ready = 1'b1;

    // 4: start re-pulse and relu flip mid-drain are ignored
    run_full("t4", 1'b0, 1'b1);

    // 5: reset at row 30, then fresh drain from address 0
    @(negedge clk);
    start = 1'b1; relu_en = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk_row("t5_row30", out_data, exp_row(30, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("t5_rst");
    reset = 1'b0;
    run_full("t5", 1'b0, 1'b0);

    // 6: single-row build
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0;
        chk_bit("t6_cen_t1", cen1, 1'b0);
        chk_int("t6_addr_t1", int'(addr1), 0);
        chk_bit("t6_busy_t1", busy1, 1'b1);
      end
      chk_bit($sformatf("t6_valid_k%0d", k), out_valid1, (k == 3));
      chk_bit($sformatf("t6_done_k%0d", k), done1, (k == 4));
      if (k == 3) begin
        chk_bit("t6_last", out_last1, 1'b1);
        chk_row("t6_data", out_data1, exp_row(0, 1'b0));
      end
      if (k == 4) chk_bit("t6_busy_end", busy1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
